// File: rtl/counter_arbiter_if.sv
// rtl/counter_arbiter_if.sv - requester and shared-counter signals of counter_arbiter
interface counter_arbiter_if #(
    parameter int WIDTH = 4
);
    logic [1:0]       req;
    logic [WIDTH-1:0] req_len0;
    logic [WIDTH-1:0] req_len1;
    logic [1:0]       grant;
    logic [1:0]       done;
    logic             busy;
    logic [WIDTH-1:0] cnt_value;
    logic             cnt_enable;
    logic             cnt_reset;

    modport master (
        output req, req_len0, req_len1, cnt_value,
        input  grant, done, busy, cnt_enable, cnt_reset
    );

    modport slave (
        input  req, req_len0, req_len1, cnt_value,
        output grant, done, busy, cnt_enable, cnt_reset
    );
endinterface

// File: rtl/counter_arbiter.sv
// rtl/counter_arbiter.sv - shares one up-counter between two delay requesters
// COUNTER_ARB_FIXED_PRIO_EN: requester 0 always wins ties (default round-robin)
module counter_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    counter_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, CLEAR, RUN, FINISH} state_t;

    state_t           state, state_n;
    logic [1:0]       grant_q, grant_n;
    logic [1:0]       done_q, done_n;
    logic [WIDTH-1:0] len_q, len_n;
    logic             busy_q, cnt_reset_q;
    logic             owner, owner_req, at_len, pick;

    assign owner     = grant_q[1];
    assign owner_req = bus.req[owner];
    assign at_len    = (bus.cnt_value == len_q);

`ifdef COUNTER_ARB_FIXED_PRIO_EN
    assign pick = (bus.req == 2'b10);
`else
    logic rr_q, rr_n;
    assign pick = (bus.req == 2'b11) ? rr_q : bus.req[1];
`endif

    always_comb begin
        state_n = state;
        grant_n = grant_q;
        len_n   = len_q;
`ifndef COUNTER_ARB_FIXED_PRIO_EN
        rr_n    = rr_q;
`endif
        case (state)
            IDLE: begin
                if (bus.req != 2'b00) begin
                    grant_n = pick ? 2'b10 : 2'b01;
                    len_n   = pick ? bus.req_len1 : bus.req_len0;
                    state_n = CLEAR;
                end
            end
            CLEAR, RUN: begin
                // An abandoned transfer still hands the tie-break to the other side
                if (!owner_req) begin
                    state_n = IDLE;
                    grant_n = 2'b00;
`ifndef COUNTER_ARB_FIXED_PRIO_EN
                    rr_n    = ~owner;
`endif
                end else if (state == CLEAR) begin
                    state_n = (len_q == '0) ? FINISH : RUN;
                end else if (at_len) begin
                    state_n = FINISH;
                end
            end
            FINISH: begin
                state_n = IDLE;
                grant_n = 2'b00;
`ifndef COUNTER_ARB_FIXED_PRIO_EN
                rr_n    = ~owner;
`endif
            end
            default: state_n = IDLE;
        endcase
        done_n = (state_n == FINISH) ? grant_q : 2'b00;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            grant_q     <= 2'b00;
            done_q      <= 2'b00;
            len_q       <= '0;
            busy_q      <= 1'b0;
            cnt_reset_q <= 1'b1;
`ifndef COUNTER_ARB_FIXED_PRIO_EN
            rr_q        <= 1'b0;
`endif
        end else begin
            state       <= state_n;
            grant_q     <= grant_n;
            done_q      <= done_n;
            len_q       <= len_n;
            busy_q      <= (state_n != IDLE);
            cnt_reset_q <= (state_n == CLEAR);
`ifndef COUNTER_ARB_FIXED_PRIO_EN
            rr_q        <= rr_n;
`endif
        end
    end

    // Combinational so the counter stops exactly on len_q and halts at once on abandon
    assign bus.cnt_enable = (state == RUN) && owner_req && !at_len;
    assign bus.grant      = grant_q;
    assign bus.done       = done_q;
    assign bus.busy       = busy_q;
    assign bus.cnt_reset  = cnt_reset_q;
endmodule

// File: tb/tb_counter_arbiter.sv
// tb/tb_counter_arbiter.sv - directed self-checking bench for counter_arbiter
module tb_counter_arbiter;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] cnt = 4'd0;
    int         n_checks = 0;
    int         n_pass = 0;

    counter_arbiter_if #(.WIDTH(4)) bus ();

    counter_arbiter #(.WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Shared 4-bit counter the arbiter drives
    always @(posedge clk) begin
        if (bus.cnt_reset)
            cnt <= 4'd0;
        else if (bus.cnt_enable)
            cnt <= cnt + 4'd1;
    end
    assign bus.cnt_value = cnt;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus.req = 2'b00;
        step();
        step();
        reset = 1'b1;
    endtask

    initial begin
        int own [4];
        int exp_own [4];
        int n_own, n_done, viol, done_edge;
        logic [1:0] prev_g, prev_d, g;
        logic en_hi;

`ifdef COUNTER_ARB_FIXED_PRIO_EN
        exp_own = '{0, 0, 0, 0};
`else
        exp_own = '{0, 1, 0, 1};
`endif
        bus.req = 2'b11;
        bus.req_len0 = 4'd0;
        bus.req_len1 = 4'd0;

        // Reset held with both requests active
        step(); step(); step();
        check("rst_grant", bus.grant, 2'b00);
        check("rst_done", bus.done, 2'b00);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_cnt_reset", bus.cnt_reset, 1'b1);
        reset = 1'b1;
        step();
        check("rst_release_grant", bus.grant, 2'b01);

        // Single request, length 5
        do_reset();
        bus.req = 2'b01;
        bus.req_len0 = 4'd5;
        step();
        check("single_grant", bus.grant, 2'b01);
        check("single_busy", bus.busy, 1'b1);
        check("single_cnt_reset", bus.cnt_reset, 1'b1);
        step();
        check("single_cnt0", bus.cnt_value, 4'd0);
        for (int k = 1; k <= 5; k++) begin
            step();
            check($sformatf("single_cnt%0d", k), bus.cnt_value, k);
            check($sformatf("single_nodone%0d", k), bus.done, 2'b00);
        end
        check("single_en_low", bus.cnt_enable, 1'b0);
        bus.req_len0 = 4'd9;
        step();
        check("single_done", bus.done, 2'b01);
        check("single_grant_held", bus.grant, 2'b01);
        bus.req = 2'b00;
        step();
        check("single_done_off", bus.done, 2'b00);
        check("single_grant_off", bus.grant, 2'b00);
        check("single_idle", bus.busy, 1'b0);

        // Both requesting continuously
        do_reset();
        bus.req = 2'b11;
        bus.req_len0 = 4'd3;
        bus.req_len1 = 4'd2;
        n_own = 0; n_done = 0; viol = 0;
        prev_g = 2'b00; prev_d = 2'b00;
        for (int c = 0; c < 80 && n_done < 4; c++) begin
            step();
            g = bus.grant;
            if (g != 2'b00 && prev_g == 2'b00 && n_own < 4) begin
                own[n_own] = int'(g[1]);
                n_own++;
            end
            if (prev_g != 2'b00 && g != 2'b00 && g != prev_g) viol++;
            if (bus.done != 2'b00 && prev_d != 2'b00) viol++;
            if (bus.done != 2'b00 && bus.done != g) viol++;
            if (bus.done != 2'b00) n_done++;
            prev_g = g;
            prev_d = bus.done;
        end
        check("rr_done_count", n_done, 4);
        check("rr_violations", viol, 0);
        for (int i = 0; i < 4; i++)
            check($sformatf("rr_owner%0d", i), own[i], exp_own[i]);

        // Zero-length request from requester 1
        do_reset();
        bus.req = 2'b10;
        bus.req_len1 = 4'd0;
        en_hi = 1'b0; n_done = 0; done_edge = 0;
        for (int c = 1; c <= 6; c++) begin
            step();
            if (bus.cnt_enable) en_hi = 1'b1;
            if (bus.done != 2'b00) begin
                check("zero_done_val", bus.done, 2'b10);
                n_done++;
                done_edge = c;
                bus.req = 2'b00;
            end
        end
        check("zero_done_count", n_done, 1);
        check("zero_done_prompt", (done_edge >= 1 && done_edge <= 3), 1'b1);
        check("zero_en_never", en_hi, 1'b0);

        // Abandon at count 4 with requester 1 pending
        do_reset();
        bus.req = 2'b01;
        bus.req_len0 = 4'd10;
        bus.req_len1 = 4'd1;
        step();
        check("ab_grant0", bus.grant, 2'b01);
        bus.req = 2'b11;
        for (int c = 0; c < 20 && bus.cnt_value != 4'd4; c++)
            step();
        check("ab_reach4", bus.cnt_value, 4'd4);
        bus.req = 2'b10;
        #1;
        check("ab_en_low", bus.cnt_enable, 1'b0);
        step();
        check("ab_grant_off", bus.grant, 2'b00);
        check("ab_no_done", bus.done, 2'b00);
        check("ab_idle", bus.busy, 1'b0);
        step();
        check("ab_pending_grant", bus.grant, 2'b10);

        // Reset in the middle of a run
        do_reset();
        bus.req = 2'b01;
        bus.req_len0 = 4'd8;
        for (int c = 0; c < 20 && bus.cnt_value != 4'd3; c++)
            step();
        check("mid_reach3", bus.cnt_value, 4'd3);
        reset = 1'b0;
        step();
        check("mid_grant", bus.grant, 2'b00);
        check("mid_busy", bus.busy, 1'b0);
        check("mid_done", bus.done, 2'b00);
        step();
        check("mid_cnt_cleared", bus.cnt_value, 4'd0);
        check("mid_done2", bus.done, 2'b00);
        bus.req = 2'b00;
        reset = 1'b1;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
